// File: rtl/mmio_initiator.sv
// Host-side MMIO initiator: issues one-cycle MMIO write/read request pulses from a
// command stream and matches read responses by TID, with timeout and stray counting.
module mmio_initiator #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TID_W          = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_wr,
    input  logic [15:0]      cmd_addr,
    input  logic [63:0]      cmd_wdata,
    output logic             mmio_wr_valid,
    output logic             mmio_rd_valid,
    output logic [15:0]      mmio_addr,
    output logic [1:0]       mmio_len,
    output logic [TID_W-1:0] mmio_tid,
    output logic [63:0]      mmio_data,
    input  logic             rd_rsp_valid,
    input  logic [TID_W-1:0] rd_rsp_tid,
    input  logic [63:0]      rd_rsp_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [63:0]      rsp_data,
    output logic             rsp_err,
    output logic [7:0]       stray_cnt
);

    // Handshakes (cmd_*, rsp_*) are valid/ready: a transfer happens on the clock edge
    // where both are high; the side holding valid keeps its payload stable until then.

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, RESP} state_t;

    state_t            state, state_d;
    logic [TID_W-1:0]  tid_q, tid_d;
    logic [CNT_W-1:0]  wait_cnt, wait_cnt_d;

    logic              cmd_ready_d, wr_valid_d, rd_valid_d;
    logic [15:0]       addr_d;
    logic [1:0]        len_d;
    logic [TID_W-1:0]  tid_out_d;
    logic [63:0]       data_d;
    logic              rsp_valid_d, rsp_err_d;
    logic [63:0]       rsp_data_d;
    logic [7:0]        stray_d;

    logic accept, rsp_match, timeout_hit;

    assign accept      = cmd_valid & cmd_ready;
    assign rsp_match   = rd_rsp_valid && (rd_rsp_tid == mmio_tid);
    assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d     = state;
        tid_d       = tid_q;
        wait_cnt_d  = wait_cnt;
        wr_valid_d  = 1'b0;
        rd_valid_d  = 1'b0;
        addr_d      = mmio_addr;
        len_d       = mmio_len;
        tid_out_d   = mmio_tid;
        data_d      = mmio_data;
        rsp_valid_d = rsp_valid;
        rsp_data_d  = rsp_data;
        rsp_err_d   = rsp_err;
        stray_d     = stray_cnt;

        case (state)
            IDLE: begin
                if (accept) begin
                    if (cmd_addr[0]) begin
                        // Misaligned: reads fail locally, writes vanish; nothing reaches the bus.
                        if (!cmd_wr) begin
                            state_d     = RESP;
                            rsp_valid_d = 1'b1;
                            rsp_data_d  = '0;
                            rsp_err_d   = 1'b1;
                        end
                    end else begin
                        state_d    = ISSUE;
                        wr_valid_d = cmd_wr;
                        rd_valid_d = !cmd_wr;
                        addr_d     = cmd_addr;
                        len_d      = 2'b01;
                        tid_out_d  = tid_q;
                        data_d     = cmd_wr ? cmd_wdata : '0;
                    end
                end
            end
            ISSUE: begin
                if (mmio_rd_valid) begin
                    state_d    = WAIT_RSP;
                    wait_cnt_d = '0;
                    tid_d      = tid_q + TID_W'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_RSP: begin
                // A match on the timeout cycle still completes successfully.
                if (rsp_match) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = rd_rsp_data;
                    rsp_err_d   = 1'b0;
                end else if (timeout_hit) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt + CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (rd_rsp_valid && !(state == WAIT_RSP && rsp_match) && stray_cnt != 8'hFF) begin
            stray_d = stray_cnt + 8'd1;
        end

        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            tid_q         <= '0;
            wait_cnt      <= '0;
            cmd_ready     <= 1'b0;
            mmio_wr_valid <= 1'b0;
            mmio_rd_valid <= 1'b0;
            mmio_addr     <= '0;
            mmio_len      <= '0;
            mmio_tid      <= '0;
            mmio_data     <= '0;
            rsp_valid     <= 1'b0;
            rsp_data      <= '0;
            rsp_err       <= 1'b0;
            stray_cnt     <= '0;
        end else begin
            state         <= state_d;
            tid_q         <= tid_d;
            wait_cnt      <= wait_cnt_d;
            cmd_ready     <= cmd_ready_d;
            mmio_wr_valid <= wr_valid_d;
            mmio_rd_valid <= rd_valid_d;
            mmio_addr     <= addr_d;
            mmio_len      <= len_d;
            mmio_tid      <= tid_out_d;
            mmio_data     <= data_d;
            rsp_valid     <= rsp_valid_d;
            rsp_data      <= rsp_data_d;
            rsp_err       <= rsp_err_d;
            stray_cnt     <= stray_d;
        end
    end

endmodule

// File: doc/mmio_initiator.md
# mmio_initiator

Host-side CCI-P MMIO initiator: turns a simple command stream (read/write, DWORD address, 64-bit data) into single-cycle MMIO write/read request pulses toward an AFU's Rx c0 port, then matches the AFU's Tx c2 read responses by TID and returns the data. It is the requester counterpart to the AFU's MMIO responder. It is used as a synthesizable traffic source in loopback builds and as the driver in AFU testbenches.

## Interface
- TIMEOUT_CYCLES, 64: cycles in WAIT_RSP before a read completes with error.
- TID_W, 9: MMIO transaction-ID width.
- clk  in  1  single clock
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_wr  in  1  1 = write, 0 = read
- cmd_addr  in  16  MMIO address in 4-byte units
- cmd_wdata  in  64  write data
- mmio_wr_valid  out  1  one-cycle write request pulse (to rx.c0.mmioWrValid)
- mmio_rd_valid  out  1  one-cycle read request pulse (to rx.c0.mmioRdValid)
- mmio_addr  out  16  request address (ReqMmioHdr.address)
- mmio_len  out  2  request length, always 2'b01 (8 bytes)
- mmio_tid  out  TID_W  request TID
- mmio_data  out  64  write data (rx.c0.data[63:0]); 0 for reads
- rd_rsp_valid  in  1  AFU read response (tx.c2.mmioRdValid)
- rd_rsp_tid  in  TID_W  response TID (tx.c2.hdr.tid)
- rd_rsp_data  in  64  response data (tx.c2.data)
- rsp_valid  out  1  read result available; held until rsp_ready
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  64  read data; 0 on error
- rsp_err  out  1  1 = timeout or misaligned address
- stray_cnt  out  8  saturating count of unmatched rd_rsp_valid pulses

## Operation
- FSM states: IDLE, ISSUE, WAIT_RSP, RESP.
- IDLE: cmd_ready = 1. On accept, latch cmd fields and go to ISSUE. An odd cmd_addr (not 8-byte aligned) is the exception: for a read, go straight to RESP with rsp_err = 1 and rsp_data = 0. For a write, drop it silently and stay in IDLE. No bus activity in either case.
- ISSUE (exactly 1 cycle): assert mmio_wr_valid or mmio_rd_valid, with mmio_addr, mmio_len = 2'b01, and mmio_tid driven.
  - Write: return to IDLE.
  - Read: go to WAIT_RSP and clear the timeout counter.
- WAIT_RSP: rd_rsp_valid with rd_rsp_tid == the issued TID captures rd_rsp_data; rsp_err = 0; go to RESP.
  - rd_rsp_valid with a different TID: stray_cnt += 1 (saturates at 255); keep waiting.
  - Counter reaches TIMEOUT_CYCLES without a match: rsp_data = 0, rsp_err = 1, go to RESP.
  - Match in the same cycle as the timeout: the match wins.
- RESP: rsp_valid = 1, with data and err stable, until rsp_ready; then go to IDLE.
- Any rd_rsp_valid outside WAIT_RSP (including late responses after a timeout) increments stray_cnt.
- TID: a counter that advances by 1 after each issued read and wraps from 2^TID_W-1 to 0. Writes carry the current TID and do not advance it.
- Only one read is outstanding at a time.

## Timing
- All outputs are registered.
- Reset values: cmd_ready 0, mmio_wr_valid 0, mmio_rd_valid 0, mmio_addr 0, mmio_len 0, mmio_tid 0, mmio_data 0, rsp_valid 0, rsp_data 0, rsp_err 0, stray_cnt 0. The internal TID counter resets to 0 and the FSM resets to IDLE.
- cmd_ready rises on the first clk edge after rst_n deasserts.
- Command accepted at edge N: request pulse high for cycle N+1 only.
  - Write: cmd_ready high again in cycle N+2, giving 2-cycle write throughput.
- Read response matched at edge M: rsp_valid is high from cycle M+1.
  - Minimum read latency is 3 cycles from accept to rsp_valid with a responder that answers 1 cycle after the request.
- Timeout: rsp_valid asserts TIMEOUT_CYCLES+1 cycles after the read pulse.
- Misaligned read: rsp_valid is high the cycle after accept.
- Asserting rst_n low mid-transaction aborts immediately: all outputs go to their reset values and no response is produced. A response that arrives after reset release counts as stray.

## Test plan
- Write cmd addr 0x0020, data 0xDEADBEEF_01234567 -> one-cycle mmio_wr_valid with mmio_addr 0x0020, mmio_len 2'b01, mmio_data equal to the write data; cmd_ready low for exactly one cycle.
- Read addr 0x0000; responder returns the matching TID 1 cycle later with 0x1000_0100_0000_0000 -> rsp_valid 3 cycles after accept, rsp_data equal to that value, rsp_err 0; rsp_ready held low 5 cycles -> output stays stable.
- Read with no responder -> rsp_err 1, rsp_data 0 at TIMEOUT_CYCLES+1 after the pulse; a late response afterwards increments stray_cnt to 1.
- In WAIT_RSP, inject a response with TID+1, then the correct TID -> stray_cnt 1, correct data returned.
- 512 back-to-back reads -> mmio_tid sequence 0..511, then wraps to 0 on the 513th read.
- Read addr 0x0021 -> no mmio_rd_valid, rsp_err 1 next cycle. Write addr 0x0021 -> no mmio_wr_valid. Reset asserted in WAIT_RSP -> all outputs 0 asynchronously, and cmd_ready returns 1 cycle after release.
